// File: rtl/pkt_send_driver_pkg.sv
// Shared packet layout definitions for the SPART packet send and read drivers.
package pkt_send_driver_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic [1:0] ADDR_X      = 2'b01;
  localparam logic [1:0] ADDR_Y      = 2'b10;

  localparam int PKT_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_TBR = 2'd1,
    ST_GAP      = 2'd2,
    ST_DONE     = 2'd3
  } pkt_state_e;

  typedef struct packed {
    logic [15:0] status;
    logic [15:0] x;
    logic [15:0] y;
  } pkt_words_t;

endpackage

// File: rtl/pkt_send_driver_byte_mux.sv
// Picks one byte of a packet by index: status, x, y, each high byte first.
module pkt_byte_mux
  import pkt_send_driver_pkg::*;
(
  input  pkt_words_t  words,
  input  logic [2:0]  index,
  output logic [7:0]  sel_byte
);

  always_comb begin
    case (index)
      3'd0:    sel_byte = words.status[15:8];
      3'd1:    sel_byte = words.status[7:0];
      3'd2:    sel_byte = words.x[15:8];
      3'd3:    sel_byte = words.x[7:0];
      3'd4:    sel_byte = words.y[15:8];
      3'd5:    sel_byte = words.y[7:0];
      default: sel_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/pkt_send_driver.sv
// Snapshots the staged status/x/y words and paces six bytes into the SPART
// transmitter using the tbr handshake; every output is a flop.
module pkt_send_driver
  import pkt_send_driver_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        send,
  input  logic        tbr,
  output logic        iocs,
  output logic        tx_write,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);
  localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);

  pkt_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic       pending_q, pending_d;
  pkt_words_t staging_q, staging_d;
  pkt_words_t snap_q, snap_d;
  logic       tx_write_d;
  logic       in_flight;
  logic [7:0] byte_d;

  // Staging with this cycle's write folded in, so a start coinciding with
  // a write snapshots the new value.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    staging_d = staging_q;
    if (wr) begin
      case (addr)
        ADDR_STATUS: staging_d.status = data_in;
        ADDR_X:      staging_d.x      = data_in;
        ADDR_Y:      staging_d.y      = data_in;
        default:     ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    pending_d  = pending_q;
    snap_d     = snap_q;
    tx_write_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (send || pending_q) begin
          snap_d    = staging_d;
          pending_d = 1'b0;
          idx_d     = 3'd0;
          state_d   = ST_WAIT_TBR;
        end
      end
      ST_WAIT_TBR: begin
        if (tbr) begin
          tx_write_d = 1'b1;
          gap_d      = GAP_LOAD;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_WAIT_TBR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // One-deep request memory; a send in DONE is caught here too.
    if (state_q != ST_IDLE && send) pending_d = 1'b1;
  end

  assign in_flight = (state_d == ST_WAIT_TBR) || (state_d == ST_GAP);

  pkt_byte_mux u_byte_mux (
    .words    (snap_d),
    .index    (idx_d),
    .sel_byte (byte_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      gap_q     <= 4'd0;
      pending_q <= 1'b0;
      staging_q <= '0;
      snap_q    <= '0;
      iocs      <= 1'b0;
      tx_write  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      staging_q <= staging_d;
      snap_q    <= snap_d;
      iocs      <= in_flight;
      tx_write  <= tx_write_d;
      tx_data   <= in_flight ? byte_d : 8'h00;
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pkt_send_driver.sv
// Self-checking bench for pkt_send_driver: table-driven packets plus
// hand-written stall, mid-packet write, pending-send and reset sequences.
module tb_pkt_send_driver;
  import pkt_send_driver_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic [15:0] data_in;
  logic        wr;
  logic        send;
  logic        tbr;
  logic        iocs;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic prev_write = 1'b0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] status;
    logic [15:0] x;
    logic [15:0] y;
    logic [47:0] exp_bytes;
    int          stall_at;
    int          exp_len;
  } vec_t;

  vec_t vecs[3];

  pkt_send_driver #(.GAP_CYCLES(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .send     (send),
    .tbr      (tbr),
    .iocs     (iocs),
    .tx_write (tx_write),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every tx_write must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      prev_write <= 1'b0;
    end else begin
      if (tx_write) begin
        check("back_to_back_write", prev_write, 0);
        check("iocs_on_write", iocs, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected no byte", tx_data);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
      end
      if (done) done_cnt <= done_cnt + 1;
      prev_write <= tx_write;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [1:0] a, input logic [15:0] d);
    addr = a; data_in = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic push_pkt(input logic [47:0] bytes);
    for (int i = 0; i < 6; i++) exp_q.push_back(bytes[47-8*i -: 8]);
  endtask

  task automatic pulse_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic run_packet(input logic [47:0] bytes, input int stall_at, output int cycles);
    int  wc;
    bit  stalled;
    wc = 0;
    stalled = 0;
    push_pkt(bytes);
    pulse_send();
    cycles = 1;
    while (done !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
      if (tx_write) wc++;
      if (stall_at >= 0 && wc == stall_at && !stalled) begin
        stalled = 1;
        tbr = 1'b0;
        for (int i = 0; i < 10; i++) begin
          tick();
          cycles++;
          check("stall_no_write", tx_write, 0);
          check("stall_data_steady", tx_data, bytes[47-8*stall_at -: 8]);
          check("stall_iocs", iocs, 1);
        end
        tbr = 1'b1;
      end
    end
    check("packet_done", done, 1);
  endtask

  task automatic post_packet();
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("tx_data_idle", tx_data, 0);
    check("iocs_idle", iocs, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int len;
    int base;
    int wc;
    int cnt;

    vecs[0] = '{16'hA55A, 16'h0123, 16'hFEDC, 48'hA55A_0123_FEDC, -1, 13};
    vecs[1] = '{16'hA55A, 16'h0123, 16'hFEDC, 48'hA55A_0123_FEDC,  2, -1};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h8001, 48'h0000_FFFF_8001, -1, 13};

    rst = 1'b1; tbr = 1'b1; addr = 2'b00; data_in = 16'h0; wr = 1'b0; send = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset_iocs", iocs, 0);
    check("reset_tx_write", tx_write, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    for (int v = 0; v < 3; v++) begin
      write_word(ADDR_STATUS, vecs[v].status);
      write_word(ADDR_X, vecs[v].x);
      write_word(ADDR_Y, vecs[v].y);
      run_packet(vecs[v].exp_bytes, vecs[v].stall_at, len);
      if (vecs[v].exp_len > 0) check("packet_length", len, vecs[v].exp_len);
      post_packet();
    end

    // Staging write during a packet affects only the next packet.
    write_word(ADDR_STATUS, 16'hA55A);
    write_word(ADDR_X, 16'h0123);
    write_word(ADDR_Y, 16'hFEDC);
    push_pkt(48'hA55A_0123_FEDC);
    pulse_send();
    tick(); tick();
    write_word(ADDR_X, 16'h7777);
    check("busy_during_write", busy, 1);
    wait_done(len);
    post_packet();
    run_packet(48'hA55A_7777_FEDC, -1, len);
    check("packet_length_x7777", len, 13);
    post_packet();

    // Two sends while busy plus one on DONE give exactly one extra packet.
    base = done_cnt;
    push_pkt(48'hA55A_7777_FEDC);
    pulse_send();
    tick(); tick();
    pulse_send();
    tick(); tick();
    pulse_send();
    wait_done(len);
    send = 1'b1;
    tick();
    send = 1'b0;
    check("idle_between_packets", busy, 0);
    push_pkt(48'hA55A_7777_FEDC);
    tick();
    check("restart_busy", busy, 1);
    check("restart_iocs", iocs, 1);
    check("restart_first_byte", tx_data, 8'hA5);
    wait_done(len);
    post_packet();
    repeat (20) tick();
    check("no_extra_packet", busy, 0);
    check("done_pulse_count", done_cnt - base, 2);

    // Asynchronous reset after byte 3 aborts and clears staging.
    write_word(ADDR_X, 16'h0123);
    push_pkt(48'hA55A_0123_FEDC);
    pulse_send();
    wc = 0;
    cnt = 0;
    while (wc < 4 && cnt < 100) begin
      tick();
      cnt++;
      if (tx_write) wc++;
    end
    check("reach_byte3", wc, 4);
    #6 rst = 1'b0;
    #1;
    check("abort_iocs", iocs, 0);
    check("abort_tx_write", tx_write, 0);
    check("abort_tx_data", tx_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b1;
    repeat (4) tick();
    check("no_resume_after_reset", busy, 0);
    run_packet(48'h0, -1, len);
    check("packet_length_zeroes", len, 13);
    post_packet();

    // addr 11 writes are ignored.
    write_word(ADDR_STATUS, 16'h1357);
    write_word(ADDR_X, 16'h2468);
    write_word(ADDR_Y, 16'hACE0);
    run_packet(48'h1357_2468_ACE0, -1, len);
    post_packet();
    write_word(2'b11, 16'hFFFF);
    run_packet(48'h1357_2468_ACE0, -1, len);
    check("packet_length_addr11", len, 13);
    post_packet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
